// File: rtl/rx_discard_stats_if.sv
// rx_discard_stats_if
//   Bundles the per-region discard MVB stream and the MI slave bus of
//   rx_discard_stats.
//   master modport: traffic source / software side (drives MVB and MI requests)
//   slave  modport: statistics unit (drives MI read data and ready signals)
//   MVB : RX_MVB_DISCARD[REGIONS], RX_MVB_VLD[REGIONS], RX_MVB_SRC_RDY
//   MI  : MI_DWR[32], MI_ADDR[MI_ADDR_WIDTH], MI_RD, MI_WR, MI_BE[4],
//         MI_DRD[32], MI_ARDY, MI_DRDY
interface rx_discard_stats_if #(
   parameter int unsigned REGIONS       = 4,
   parameter int unsigned MI_ADDR_WIDTH = 32
);
   logic [REGIONS-1:0]       RX_MVB_DISCARD;
   logic [REGIONS-1:0]       RX_MVB_VLD;
   logic                     RX_MVB_SRC_RDY;

   logic [31:0]              MI_DWR;
   logic [MI_ADDR_WIDTH-1:0] MI_ADDR;
   logic                     MI_RD;
   logic                     MI_WR;
   logic [3:0]               MI_BE;
   logic [31:0]              MI_DRD;
   logic                     MI_ARDY;
   logic                     MI_DRDY;

   modport master (
      output RX_MVB_DISCARD, RX_MVB_VLD, RX_MVB_SRC_RDY,
      output MI_DWR, MI_ADDR, MI_RD, MI_WR, MI_BE,
      input  MI_DRD, MI_ARDY, MI_DRDY
   );

   modport slave (
      input  RX_MVB_DISCARD, RX_MVB_VLD, RX_MVB_SRC_RDY,
      input  MI_DWR, MI_ADDR, MI_RD, MI_WR, MI_BE,
      output MI_DRD, MI_ARDY, MI_DRDY
   );
endinterface

// File: rtl/rx_discard_stats.sv
// rx_discard_stats
//   Per-channel RX frame statistics: counts total and discarded frames
//   reported on the RX MAC Lite discard MVB stream and exposes them to
//   software through an MI slave with an atomic snapshot/clear mechanism.
//
//   Ports:
//     CLK    clock
//     RESET  synchronous, active-high reset
//     bus    rx_discard_stats_if.slave (discard MVB input + MI slave)
//
//   MI map: 0x00/0x04 shadow total lo/hi, 0x08/0x0C shadow discarded lo/hi,
//           0x10 CTRL (wo: bit0 SNAPSHOT, bit1 CLEAR, needs MI_BE[0]),
//           0x14 STATUS (ro: bit0 total saturated, bit1 discarded saturated).
//
//   Build option: define RX_DISCARD_STATS_SATURATE_EN to make the live
//   counters saturate at all-ones with sticky STATUS flags; otherwise they
//   wrap and STATUS reads 0.
module rx_discard_stats #(
   parameter int unsigned REGIONS       = 4,
   parameter int unsigned CNT_WIDTH     = 64,
   parameter int unsigned MI_DATA_WIDTH = 32,
   parameter int unsigned MI_ADDR_WIDTH = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   rx_discard_stats_if.slave bus
);

   localparam int unsigned IW = $clog2(REGIONS + 1);

   typedef enum logic [2:0] {
      REG_TOT_LO = 3'd0,
      REG_TOT_HI = 3'd1,
      REG_DIS_LO = 3'd2,
      REG_DIS_HI = 3'd3,
      REG_CTRL   = 3'd4,
      REG_STATUS = 3'd5
   } reg_sel_t;

   logic [REGIONS-1:0]       vld;
   logic [REGIONS-1:0]       dis;
   logic [MI_ADDR_WIDTH-1:0] addr;
   reg_sel_t                 sel;

   logic [IW-1:0]            nxt_tot, nxt_dis;
   logic [IW-1:0]            inc_tot, inc_dis;
   logic [CNT_WIDTH-1:0]     live_tot, live_dis;
   logic [CNT_WIDTH-1:0]     acc_tot, acc_dis;
   logic                     ovf_tot, ovf_dis;
   logic [CNT_WIDTH-1:0]     shd_tot, shd_dis;
   logic                     sat_tot, sat_dis;

   logic                     ctrl_wr, snap, clr;
   logic [MI_DATA_WIDTH-1:0] rdata;
   logic [MI_DATA_WIDTH-1:0] drd_q;
   logic                     drdy_q;
   logic                     unused_mi;

   assign vld  = bus.RX_MVB_VLD;
   assign dis  = bus.RX_MVB_DISCARD;
   assign addr = bus.MI_ADDR;
   assign sel  = reg_sel_t'(addr[4:2]);

   assign unused_mi = ^{addr[MI_ADDR_WIDTH-1:5], addr[1:0],
                        bus.MI_DWR[31:2], bus.MI_BE[3:1]};

   // Stage 1: per-word popcounts of qualified frames
   always_comb begin
      nxt_tot = '0;
      nxt_dis = '0;
      for (int unsigned i = 0; i < REGIONS; i++) begin
         nxt_tot = nxt_tot + IW'(vld[i] & bus.RX_MVB_SRC_RDY);
         nxt_dis = nxt_dis + IW'(vld[i] & dis[i] & bus.RX_MVB_SRC_RDY);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         inc_tot <= '0;
         inc_dis <= '0;
      end else begin
         inc_tot <= nxt_tot;
         inc_dis <= nxt_dis;
      end
   end

   // Stage 2 accumulate
`ifdef RX_DISCARD_STATS_SATURATE_EN
   logic [CNT_WIDTH:0] sum_tot, sum_dis;

   always_comb begin
      sum_tot = {1'b0, live_tot} + (CNT_WIDTH + 1)'(inc_tot);
      sum_dis = {1'b0, live_dis} + (CNT_WIDTH + 1)'(inc_dis);
      ovf_tot = sum_tot[CNT_WIDTH];
      ovf_dis = sum_dis[CNT_WIDTH];
      acc_tot = ovf_tot ? '1 : sum_tot[CNT_WIDTH-1:0];
      acc_dis = ovf_dis ? '1 : sum_dis[CNT_WIDTH-1:0];
   end
`else
   always_comb begin
      acc_tot = live_tot + CNT_WIDTH'(inc_tot);
      acc_dis = live_dis + CNT_WIDTH'(inc_dis);
      ovf_tot = 1'b0;
      ovf_dis = 1'b0;
   end
`endif

   assign ctrl_wr = bus.MI_WR && (sel == REG_CTRL) && bus.MI_BE[0];
   assign snap    = ctrl_wr & bus.MI_DWR[0];
   assign clr     = ctrl_wr & bus.MI_DWR[1];

   // CLEAR reloads the live counters with the increment in flight this cycle
   // so no frame is lost; SNAPSHOT samples the pre-update live value, which
   // yields an atomic read-and-clear when both bits are written together.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         live_tot <= '0;
         live_dis <= '0;
         shd_tot  <= '0;
         shd_dis  <= '0;
         sat_tot  <= 1'b0;
         sat_dis  <= 1'b0;
      end else begin
         if (clr) begin
            live_tot <= CNT_WIDTH'(inc_tot);
            live_dis <= CNT_WIDTH'(inc_dis);
            sat_tot  <= 1'b0;
            sat_dis  <= 1'b0;
         end else begin
            live_tot <= acc_tot;
            live_dis <= acc_dis;
            if (ovf_tot) sat_tot <= 1'b1;
            if (ovf_dis) sat_dis <= 1'b1;
         end
         if (snap) begin
            shd_tot <= live_tot;
            shd_dis <= live_dis;
         end
      end
   end

   // MI read path
   always_comb begin
      rdata = '0;
      case (sel)
         REG_TOT_LO: rdata = shd_tot[31:0];
         REG_TOT_HI: rdata = MI_DATA_WIDTH'(shd_tot[CNT_WIDTH-1:32]);
         REG_DIS_LO: rdata = shd_dis[31:0];
         REG_DIS_HI: rdata = MI_DATA_WIDTH'(shd_dis[CNT_WIDTH-1:32]);
         REG_STATUS: rdata = MI_DATA_WIDTH'({sat_dis, sat_tot});
         default:    rdata = '0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         drd_q  <= '0;
         drdy_q <= 1'b0;
      end else begin
         drdy_q <= bus.MI_RD;
         if (bus.MI_RD) drd_q <= rdata;
      end
   end

   assign bus.MI_ARDY = bus.MI_RD | bus.MI_WR;
   assign bus.MI_DRD  = drd_q;
   assign bus.MI_DRDY = drdy_q;

endmodule

// File: tb/tb_rx_discard_stats.sv
// tb_rx_discard_stats
//   Self-checking bench for rx_discard_stats (REGIONS=4, CNT_WIDTH=64).
//   The reference model keeps a per-cycle history of qualified frame counts;
//   a snapshot taken at cycle s equals the sum of frames of beats in
//   [start of current counting window, s-2], and CLEAR restarts the window
//   at beat s-1. Honours RX_DISCARD_STATS_SATURATE_EN for the overflow step.
module tb_rx_discard_stats;

   logic CLK = 1'b0;
   logic RESET;

   always #5 CLK = ~CLK;

   rx_discard_stats_if #(.REGIONS(4), .MI_ADDR_WIDTH(32)) bus ();

   rx_discard_stats #(
      .REGIONS(4),
      .CNT_WIDTH(64),
      .MI_DATA_WIDTH(32),
      .MI_ADDR_WIDTH(32)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   int unsigned     hist_tot [4096];
   int unsigned     hist_dis [4096];
   int              cyc = 0;
   int              ws  = 0;
   bit              rnd_mode = 1'b0;
   int              nbeats = 0;
   longint unsigned m_tot = 0;
   longint unsigned m_dis = 0;

   logic [31:0]     d;
   logic [63:0]     v, v2, acc;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint unsigned wsum(input bit sel_dis, input int lo, input int hi);
      longint unsigned s = 0;
      for (int i = lo; i <= hi; i++)
         if (i >= 0) s += sel_dis ? hist_dis[i] : hist_tot[i];
      return s;
   endfunction

   // One clock cycle: randomise traffic if requested, update the model from
   // the inputs presented this cycle, then advance to just after the edge.
   task automatic step();
      if (rnd_mode) begin
         bus.RX_MVB_SRC_RDY = 1'($urandom_range(0, 1));
         bus.RX_MVB_VLD     = 4'($urandom);
         bus.RX_MVB_DISCARD = 4'($urandom);
      end
      hist_tot[cyc] = bus.RX_MVB_SRC_RDY ? $countones(bus.RX_MVB_VLD) : 0;
      hist_dis[cyc] = bus.RX_MVB_SRC_RDY ? $countones(bus.RX_MVB_VLD & bus.RX_MVB_DISCARD) : 0;
      if (bus.RX_MVB_SRC_RDY && bus.RX_MVB_VLD != 4'h0) nbeats++;
      if (RESET) begin
         ws    = cyc + 1;
         m_tot = 0;
         m_dis = 0;
      end else if (bus.MI_WR && bus.MI_ADDR[4:2] == 3'd4 && bus.MI_BE[0]) begin
         if (bus.MI_DWR[0]) begin
            m_tot = wsum(1'b0, ws, cyc - 2);
            m_dis = wsum(1'b1, ws, cyc - 2);
         end
         if (bus.MI_DWR[1] && (cyc - 1) > ws) ws = cyc - 1;
      end
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] data);
      bus.MI_ADDR = a;
      bus.MI_RD   = 1'b1;
      #1;
      chk("ardy_rd", 64'(bus.MI_ARDY), 64'd1);
      step();
      chk("drdy_rd", 64'(bus.MI_DRDY), 64'd1);
      data = bus.MI_DRD;
      bus.MI_RD = 1'b0;
   endtask

   task automatic rd64(input logic [31:0] a, output logic [63:0] val);
      logic [31:0] lo, hi;
      rd(a, lo);
      rd(a + 32'd4, hi);
      val = {hi, lo};
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] data, input logic [3:0] be);
      bus.MI_ADDR = a;
      bus.MI_DWR  = data;
      bus.MI_BE   = be;
      bus.MI_WR   = 1'b1;
      step();
      bus.MI_WR = 1'b0;
      chk("drdy_wr", 64'(bus.MI_DRDY), 64'd0);
   endtask

   task automatic idle(input int n);
      bus.RX_MVB_SRC_RDY = 1'b0;
      bus.RX_MVB_VLD     = '0;
      bus.RX_MVB_DISCARD = '0;
      repeat (n) step();
   endtask

   initial begin
      RESET = 1'b1;
      bus.RX_MVB_SRC_RDY = 1'b0;
      bus.RX_MVB_VLD     = '0;
      bus.RX_MVB_DISCARD = '0;
      bus.MI_DWR  = '0;
      bus.MI_ADDR = '0;
      bus.MI_RD   = 1'b0;
      bus.MI_WR   = 1'b0;
      bus.MI_BE   = '0;

      // Reset state
      repeat (3) step();
      chk("rst_drdy", 64'(bus.MI_DRDY), 64'd0);
      chk("rst_drd", 64'(bus.MI_DRD), 64'd0);
      RESET = 1'b0;
      step();
      for (int a = 0; a < 6; a++) begin
         rd(32'(a * 4), d);
         chk("rst_read", 64'(d), 64'd0);
      end

      // 100 beats VLD=1011 DISCARD=0010
      bus.RX_MVB_SRC_RDY = 1'b1;
      bus.RX_MVB_VLD     = 4'b1011;
      bus.RX_MVB_DISCARD = 4'b0010;
      repeat (100) step();
      idle(2);
      wr(32'h10, 32'h1, 4'hF);
      rd64(32'h00, v);
      chk("fix_tot", v, 64'd300);
      chk("fix_tot_hi", 64'(v[63:32]), 64'd0);
      rd64(32'h08, v);
      chk("fix_dis", v, 64'd100);
      chk("fix_dis_hi", 64'(v[63:32]), 64'd0);
      chk("fix_model", 64'(m_tot), 64'd300);
      rd(32'h14, d);
      chk("fix_status", 64'(d), 64'd0);

      // Back-to-back reads
      bus.MI_RD = 1'b1;
      bus.MI_ADDR = 32'h00;
      step();
      chk("b2b_drdy0", 64'(bus.MI_DRDY), 64'd1);
      chk("b2b_drd0", 64'(bus.MI_DRD), 64'd300);
      bus.MI_ADDR = 32'h08;
      step();
      chk("b2b_drdy1", 64'(bus.MI_DRDY), 64'd1);
      chk("b2b_drd1", 64'(bus.MI_DRD), 64'd100);
      bus.MI_RD = 1'b0;
      step();
      chk("b2b_drdy_end", 64'(bus.MI_DRDY), 64'd0);

      // Random traffic with random SNAPSHOT/CLEAR combinations
      rnd_mode = 1'b1;
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(3, 12)) step();
         wr(32'h10, 32'($urandom_range(1, 3)), 4'hF);
         rd64(32'h00, v);
         chk("rnd_tot", v, 64'(m_tot));
         rd64(32'h08, v2);
         chk("rnd_dis", v2, 64'(m_dis));
         chk("rnd_inv", 64'(v2 <= v), 64'd1);
      end
      rnd_mode = 1'b0;

      // Beats that must not count
      idle(2);
      wr(32'h10, 32'h1, 4'hF);
      bus.RX_MVB_SRC_RDY = 1'b0;
      bus.RX_MVB_VLD     = 4'hF;
      bus.RX_MVB_DISCARD = 4'hF;
      repeat (5) step();
      bus.RX_MVB_SRC_RDY = 1'b1;
      bus.RX_MVB_VLD     = 4'h0;
      repeat (5) step();
      idle(2);
      acc = 64'(m_tot);
      v2  = 64'(m_dis);
      wr(32'h10, 32'h1, 4'hF);
      rd64(32'h00, v);
      chk("null_tot", v, acc);
      rd64(32'h08, v);
      chk("null_dis", v, v2);

      // Full-rate traffic with atomic read-and-clear
      idle(2);
      wr(32'h10, 32'h2, 4'hF);
      nbeats = 0;
      acc = '0;
      bus.RX_MVB_SRC_RDY = 1'b1;
      bus.RX_MVB_VLD     = 4'hF;
      bus.RX_MVB_DISCARD = 4'b0101;
      for (int k = 0; k < 10; k++) begin
         repeat ($urandom_range(4, 15)) step();
         wr(32'h10, 32'h3, 4'hF);
         rd64(32'h00, v);
         chk("full_snap", v, 64'(m_tot));
         acc += v;
      end
      idle(2);
      wr(32'h10, 32'h1, 4'hF);
      rd64(32'h00, v);
      acc += v;
      chk("full_conserve", acc, 64'(4 * nbeats));

      // Unmapped read, write to read-only, CTRL write without BE[0]
      rd(32'h18, d);
      chk("unmapped_rd", 64'(d), 64'd0);
      wr(32'h00, 32'hFFFF_FFFF, 4'hF);
      wr(32'h10, 32'h3, 4'b1110);
      idle(2);
      wr(32'h10, 32'h1, 4'hF);
      rd64(32'h00, v);
      chk("be_tot", v, 64'(m_tot));
      rd64(32'h08, v);
      chk("be_dis", v, 64'(m_dis));

      // Reset during a read suppresses DRDY
      bus.MI_ADDR = 32'h00;
      bus.MI_RD   = 1'b1;
      RESET       = 1'b1;
      step();
      bus.MI_RD = 1'b0;
      chk("rst_rd_drdy", 64'(bus.MI_DRDY), 64'd0);
      RESET = 1'b0;
      step();
      rd64(32'h00, v);
      chk("rst_shd", v, 64'd0);

      // Counter overflow
      dut.live_tot = 64'hFFFF_FFFF_FFFF_FFFE;
      bus.RX_MVB_SRC_RDY = 1'b1;
      bus.RX_MVB_VLD     = 4'hF;
      bus.RX_MVB_DISCARD = 4'h0;
      step();
      idle(2);
      wr(32'h10, 32'h1, 4'hF);
      rd64(32'h00, v);
      rd(32'h14, d);
`ifdef RX_DISCARD_STATS_SATURATE_EN
      chk("sat_tot", v, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("sat_status", 64'(d), 64'd1);
      wr(32'h10, 32'h2, 4'hF);
      idle(2);
      wr(32'h10, 32'h1, 4'hF);
      rd64(32'h00, v);
      chk("sat_clr_tot", v, 64'd0);
      rd(32'h14, d);
      chk("sat_clr_status", 64'(d), 64'd0);
`else
      chk("wrap_tot", v, 64'd2);
      chk("wrap_status", 64'(d), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
